ovi_issue_queue: RTL

//  In-order FIFO between the scalar core's vector-instruction decode and the OVI bridge.

---
 rtl/ovi_issue_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ovi_issue_queue.sv
// In-order vector-instruction queue between core decode and the OVI bridge issue bus; tracks issued-not-completed instrs.
// Latency: 1 cycle push-to-OUT_VALID; 0 cycles when VIQ_BYPASS_EN is defined and the queue is empty.
// Backpressure: IN_READY drops when full; pops stall on CORE_HALT or when OUTSTANDING reaches MAX_OUTSTD.
`ifndef OVI_VL_WIDTH
`define OVI_VL_WIDTH 8
`endif

module ovi_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int MAX_OUTSTD = 4,
    localparam int VLW = `OVI_VL_WIDTH,
    localparam int PW  = $clog2(DEPTH),
    localparam int CW  = $clog2(DEPTH + 1),
    localparam int OW  = $clog2(MAX_OUTSTD + 1)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     IN_INSTR,
    input  logic [63:0]     IN_OPND,
    input  logic [VLW-1:0]  IN_VL,
    input  logic [2:0]      IN_SEW,
    input  logic            IN_WB,
    output logic            OUT_VALID,
    output logic [31:0]     OUT_INSTR,
    output logic [63:0]     OUT_OPND,
    output logic [VLW-1:0]  OUT_VL,
    output logic [2:0]      OUT_SEW,
    output logic            OUT_WB,
    input  logic            CORE_HALT,
    input  logic            COMPLETE,
    output logic [OW-1:0]   OUTSTANDING,
    output logic [CW-1:0]   COUNT,
    output logic            IDLE,
    output logic            ERR
);

    typedef struct packed {
        logic [31:0]    instr;
        logic [63:0]    opnd;
        logic [VLW-1:0] vl;
        logic [2:0]     sew;
        logic           wb;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic            err_q, err_d;

    entry_t in_ent;
    entry_t head_ent;
    logic   not_full;
    logic   at_cap;
    logic   push;
    logic   pop;
    logic   byp_sel;
    logic   wr_en;
    logic   rd_en;
    logic   cpl_ok;

    assign in_ent   = '{instr: IN_INSTR, opnd: IN_OPND, vl: IN_VL, sew: IN_SEW, wb: IN_WB};
    assign not_full = (count_q != CW'(DEPTH));
    assign at_cap   = (outst_q == OW'(MAX_OUTSTD));
    assign push     = IN_VALID && not_full;

`ifdef VIQ_BYPASS_EN
    // An empty queue forwards the offered instruction straight to the issue bus.
    assign byp_sel   = (count_q == '0) && IN_VALID;
    assign head_ent  = byp_sel ? in_ent : mem_q[rd_ptr_q];
    assign OUT_VALID = ((count_q != '0) || IN_VALID) && !at_cap;
`else
    assign byp_sel   = 1'b0;
    assign head_ent  = mem_q[rd_ptr_q];
    assign OUT_VALID = (count_q != '0) && !at_cap;
`endif

    assign pop    = OUT_VALID && !CORE_HALT;
    // A bypassed entry that issues immediately never touches storage or pointers.
    assign wr_en  = push && !(byp_sel && pop);
    assign rd_en  = pop && !byp_sel;
    assign cpl_ok = COMPLETE && (outst_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        outst_d  = outst_q;
        err_d    = err_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && rd_en) begin
            count_d = count_q - CW'(1);
        end
        if (pop && !cpl_ok) begin
            outst_d = outst_q + OW'(1);
        end else if (!pop && cpl_ok) begin
            outst_d = outst_q - OW'(1);
        end
        if (COMPLETE && (outst_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_ent;
        end
    end

    assign IN_READY    = not_full;
    assign OUT_INSTR   = head_ent.instr;
    assign OUT_OPND    = head_ent.opnd;
    assign OUT_VL      = head_ent.vl;
    assign OUT_SEW     = head_ent.sew;
    assign OUT_WB      = head_ent.wb;
    assign OUTSTANDING = outst_q;
    assign COUNT       = count_q;
    assign IDLE        = (count_q == '0) && (outst_q == '0);
    assign ERR         = err_q;

endmodule
